mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single-port memory_wrapper between the systolic-array operand loader (port 0) and the result writeback/image path (port 1).
- Issues at most one command per cycle to the wrapper, gated by the wrapper's read_ready/write_ready.
- Tracks the owner of every outstanding read in an in-order tag FIFO and returns each read_data, registered, to the requester that issued it.
- Sits between the requesters and memory_wrapper; the wrapper is unmodified.

Parameters:
- DATA_WIDTH, 32, data and address width of all buses.
- MAX_OUTSTANDING, 4, depth of the read-owner tag FIFO, and therefore the maximum number of reads in flight (power of 2, ≥2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 command valid
- req0_we  in  1  1 = write, 0 = read
- req0_be  in  1  1 = byte access, 0 = word access
- req0_addr  in  DATA_WIDTH  byte address
- req0_wdata  in  DATA_WIDTH  write data
- req0_ready  out  1  command accepted this cycle (valid & ready = transfer)
- rsp0_valid  out  1  read response valid (1-cycle pulse)
- rsp0_data  out  DATA_WIDTH  read response data
- req1_* / rsp1_*  same set as port 0, for requester 1
- mem_address  out  DATA_WIDTH  to wrapper address
- mem_write_data  out  DATA_WIDTH  to wrapper write_data
- mem_we  out  1  to wrapper we
- mem_re  out  1  to wrapper re
- mem_be  out  1  to wrapper be
- mem_read_data  in  DATA_WIDTH  from wrapper read_data
- mem_read_valid  in  1  from wrapper read_valid
- mem_read_ready  in  1  from wrapper read_ready
- mem_write_ready  in  1  from wrapper write_ready
- grant_count0  out  32  accepted commands, port 0
- grant_count1  out  32  accepted commands, port 1
- tag_error  out  1  sticky: read_valid received with tag FIFO empty

Behaviour:
- Reset (synchronous, checked on posedge clk): all outputs 0. Tag FIFO emptied. Counters 0. tag_error 0. last_grant = 1, so port 0 wins the first contention.
- Eligibility: a port is eligible when reqN_valid is high and one of these holds:
  - the command is a write and mem_write_ready is high;
  - the command is a read, mem_read_ready is high, and the tag FIFO is not full.
- Arbitration is combinational within the cycle:
  - one eligible port: grant it;
  - both eligible: grant the port != last_grant.
- A non-eligible valid port never blocks an eligible one.
- Issue:
  - reqN_ready = 1 only for the granted port.
  - mem_* fields are driven from the granted port.
  - mem_we = granted & we; mem_re = granted & ~we.
  - mem_we and mem_re are never both high.
  - With no grant: mem_we = mem_re = 0 and address/data hold the port-0 values.
- On every transfer:
  - last_grant <= granted port id;
  - grant_countN increments (wraps at 2^32).
- last_grant does not change in idle cycles.
- Tag FIFO:
  - push the port id when a read transfers;
  - pop on mem_read_valid;
  - a push and a pop in the same cycle are both performed, and the occupancy count is unchanged.
- Response path, registered with 1 cycle of latency after mem_read_valid:
  - rspN_valid <= mem_read_valid & (head tag == N);
  - rspN_data <= mem_read_data when rspN_valid is set, else 0.
- End-to-end read latency is wrapper latency + 1: the response appears 3 cycles after the accepting edge when READ_LATENCY = 2.
- Responses return strictly in issue order.
- Error case: mem_read_valid with the FIFO empty sets tag_error sticky until reset. The data is dropped and no rsp is asserted.
- Writes produce no response.
- A requester must hold its command stable while valid && !ready (the arbiter does not check this).
- Reset mid-read: the FIFO is cleared and in-flight responses are discarded. No rsp is asserted during the reset cycle or the cycle after it.

Test Plan:
- Single read, port 0: req0 read addr 0x10 with memory word 0xDEADBEEF → req0_ready 1 for one cycle, mem_re 1; rsp0_valid pulses 3 cycles later with 0xDEADBEEF; rsp1_valid stays 0.
- Contention: both ports request writes every cycle with ready held high → grants alternate 0,1,0,1 starting with port 0; after 8 cycles grant_count0 = grant_count1 = 4.
- Interleaved reads: port 0 reads 0x0 (0x11111111), then port 1 reads 0x4 (0x22222222) → rsp0 returns 0x11111111 before rsp1 returns 0x22222222; no cross-routing.
- Back-pressure: mem_read_ready = 0 with a port-0 read and a port-1 write pending → port 1 granted; port 0's ready stays 0 until mem_read_ready = 1.
- FIFO full: hold mem_read_valid low with 4 reads outstanding → the 5th read is not granted; pulse mem_read_valid once → the 5th read is granted in that same cycle.
- Error and reset: pulse mem_read_valid with no read outstanding → tag_error = 1, no rsp asserted; assert reset → tag_error, both counters and all rsp outputs read 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------------------------
// mem_arbiter
//
// Two-requester round-robin arbiter in front of the single-port memory_wrapper. Port 0 is the
// systolic-array operand loader, port 1 the result writeback / image path. At most one command
// is issued to the wrapper per cycle, gated by the wrapper's read_ready / write_ready. The owner
// of every outstanding read is kept in an in-order tag FIFO so that each read_data beat can be
// routed back, registered, to the requester that issued it.
//
// Parameters
//   DATA_WIDTH       width of all address and data buses
//   MAX_OUTSTANDING  depth of the read-owner tag FIFO = max reads in flight (power of 2, >= 2)
//
// Ports
//   clk, reset                         system clock, synchronous active-high reset
//   reqN_valid/we/be/addr/wdata        command from requester N (we: 1 = write, be: 1 = byte)
//   reqN_ready                         command of requester N accepted this cycle
//   rspN_valid/data                    registered read response to requester N (1-cycle pulse)
//   mem_address/write_data/we/re/be    command to the wrapper
//   mem_read_data/read_valid           read return from the wrapper
//   mem_read_ready/write_ready         wrapper can take a read / write this cycle
//   grant_count0/1                     free-running count of accepted commands per port
//   tag_error                          sticky: read_valid seen while no read was outstanding
// ---------------------------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic                  req0_be,
    input  logic [DATA_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,

    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic                  req1_be,
    input  logic [DATA_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,

    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic                  mem_be,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_read_valid,
    input  logic                  mem_read_ready,
    input  logic                  mem_write_ready,

    output logic [31:0]           grant_count0,
    output logic [31:0]           grant_count1,
    output logic                  tag_error
);

    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = PtrW + 1;

    // ---------------------------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------------------------
    logic                       last_grant_q, last_grant_d;
    logic [31:0]                cnt0_q, cnt0_d;
    logic [31:0]                cnt1_q, cnt1_d;
    logic                       tag_error_q, tag_error_d;

    logic [MAX_OUTSTANDING-1:0] tag_mem_q;
    logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]            count_q, count_d;

    logic                       rsp0_valid_q, rsp0_valid_d;
    logic                       rsp1_valid_q, rsp1_valid_d;
    logic [DATA_WIDTH-1:0]      rsp0_data_q, rsp0_data_d;
    logic [DATA_WIDTH-1:0]      rsp1_data_q, rsp1_data_d;

    // ---------------------------------------------------------------------------------------
    // Tag FIFO status
    // ---------------------------------------------------------------------------------------
    logic fifo_empty;
    logic fifo_full;
    logic fifo_can_push;
    logic head_tag;
    logic push;
    logic pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(MAX_OUTSTANDING));
    assign head_tag   = tag_mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts a read that cycle.
    assign fifo_can_push = ~fifo_full | mem_read_valid;

    // ---------------------------------------------------------------------------------------
    // Eligibility and round-robin arbitration
    // ---------------------------------------------------------------------------------------
    logic elig0;
    logic elig1;
    logic gnt0;
    logic gnt1;
    logic gnt_any;

    assign elig0 = req0_valid & (req0_we ? mem_write_ready : (mem_read_ready & fifo_can_push));
    assign elig1 = req1_valid & (req1_we ? mem_write_ready : (mem_read_ready & fifo_can_push));

    // On contention the port that did not win last time is granted.
    assign gnt0    = ~reset & elig0 & (~elig1 | last_grant_q);
    assign gnt1    = ~reset & elig1 & (~elig0 | ~last_grant_q);
    assign gnt_any = gnt0 | gnt1;

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // ---------------------------------------------------------------------------------------
    // Command mux to the wrapper
    // ---------------------------------------------------------------------------------------
    always_comb begin
        mem_address    = req0_addr;
        mem_write_data = req0_wdata;
        mem_be         = req0_be;
        mem_we         = 1'b0;
        mem_re         = 1'b0;
        if (reset) begin
            mem_address    = '0;
            mem_write_data = '0;
            mem_be         = 1'b0;
        end else if (gnt1) begin
            mem_address    = req1_addr;
            mem_write_data = req1_wdata;
            mem_be         = req1_be;
            mem_we         = req1_we;
            mem_re         = ~req1_we;
        end else if (gnt0) begin
            mem_we         = req0_we;
            mem_re         = ~req0_we;
        end
    end

    assign push = gnt_any & mem_re;
    assign pop  = mem_read_valid & ~fifo_empty;

    // ---------------------------------------------------------------------------------------
    // Next state
    // ---------------------------------------------------------------------------------------
    always_comb begin
        last_grant_d = last_grant_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        tag_error_d  = tag_error_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        if (gnt_any) begin
            last_grant_d = gnt1;
        end
        if (gnt0) begin
            cnt0_d = cnt0_q + 32'd1;
        end
        if (gnt1) begin
            cnt1_d = cnt1_q + 32'd1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A return beat with no owner is dropped and flagged.
        if (mem_read_valid && fifo_empty) begin
            tag_error_d = 1'b1;
        end

        rsp0_valid_d = pop & ~head_tag;
        rsp1_valid_d = pop & head_tag;
        rsp0_data_d  = rsp0_valid_d ? mem_read_data : '0;
        rsp1_data_d  = rsp1_valid_d ? mem_read_data : '0;
    end

    // ---------------------------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            tag_error_q  <= 1'b0;
            tag_mem_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
            tag_error_q  <= tag_error_d;
            if (push) begin
                tag_mem_q[wr_ptr_q] <= gnt1;
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign rsp0_valid   = rsp0_valid_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp0_data    = rsp0_data_q;
    assign rsp1_data    = rsp1_data_q;
    assign grant_count0 = cnt0_q;
    assign grant_count1 = cnt1_q;
    assign tag_error    = tag_error_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with a behavioural memory_wrapper (read latency 2). Expected
// read responses are pushed into a scoreboard queue when a read is issued; an independent
// monitor pops and compares whenever either rsp port is valid.
// ---------------------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        req0_valid, req0_we, req0_be;
    logic [31:0] req0_addr, req0_wdata;
    logic        req0_ready, rsp0_valid;
    logic [31:0] rsp0_data;

    logic        req1_valid, req1_we, req1_be;
    logic [31:0] req1_addr, req1_wdata;
    logic        req1_ready, rsp1_valid;
    logic [31:0] rsp1_data;

    logic [31:0] mem_address, mem_write_data;
    logic        mem_we, mem_re, mem_be;
    logic [31:0] mem_read_data;
    logic        mem_read_valid;
    logic        mem_read_ready, mem_write_ready;

    logic [31:0] grant_count0, grant_count1;
    logic        tag_error;

    always #5 clk = ~clk;

    mem_arbiter #(
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req0_valid      (req0_valid),
        .req0_we         (req0_we),
        .req0_be         (req0_be),
        .req0_addr       (req0_addr),
        .req0_wdata      (req0_wdata),
        .req0_ready      (req0_ready),
        .rsp0_valid      (rsp0_valid),
        .rsp0_data       (rsp0_data),
        .req1_valid      (req1_valid),
        .req1_we         (req1_we),
        .req1_be         (req1_be),
        .req1_addr       (req1_addr),
        .req1_wdata      (req1_wdata),
        .req1_ready      (req1_ready),
        .rsp1_valid      (rsp1_valid),
        .rsp1_data       (rsp1_data),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_we          (mem_we),
        .mem_re          (mem_re),
        .mem_be          (mem_be),
        .mem_read_data   (mem_read_data),
        .mem_read_valid  (mem_read_valid),
        .mem_read_ready  (mem_read_ready),
        .mem_write_ready (mem_write_ready),
        .grant_count0    (grant_count0),
        .grant_count1    (grant_count1),
        .tag_error       (tag_error)
    );

    // ---------------------------------------------------------------------------------------
    // Scoreboard and counters
    // ---------------------------------------------------------------------------------------
    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // ---------------------------------------------------------------------------------------
    // Behavioural memory_wrapper: a read sampled at edge c returns on the wire after edge c+2.
    // hold stalls returns, release_one forces one return, inject emits an ownerless beat.
    // ---------------------------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] addr;
        int unsigned due;
    } rd_t;

    logic [31:0] mem [0:255];
    rd_t         pend_q[$];
    int unsigned cyc = 0;
    logic        hold, release_one, inject;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            pend_q.delete();
            mem_read_valid <= 1'b0;
            mem_read_data  <= '0;
            mem[0]  <= 32'h11111111;
            mem[1]  <= 32'h22222222;
            mem[4]  <= 32'hDEADBEEF;
            mem[8]  <= 32'h30303030;
            mem[9]  <= 32'h31313131;
            mem[10] <= 32'h32323232;
            mem[11] <= 32'h33333333;
            mem[12] <= 32'h44444444;
        end else begin
            if (mem_we) begin
                mem[mem_address[9:2]] <= mem_write_data;
            end
            if (inject) begin
                mem_read_valid <= 1'b1;
                mem_read_data  <= 32'hBAD0BAD0;
            end else if (pend_q.size() > 0 &&
                         ((!hold && pend_q[0].due <= cyc) || release_one)) begin
                mem_read_valid <= 1'b1;
                mem_read_data  <= mem[pend_q[0].addr[9:2]];
                void'(pend_q.pop_front());
            end else begin
                mem_read_valid <= 1'b0;
            end
            if (mem_re) begin
                pend_q.push_back({mem_address, cyc + 32'd2});
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Response monitor
    // ---------------------------------------------------------------------------------------
    always @(negedge clk) begin
        if (!reset && (rsp0_valid || rsp1_valid)) begin
            if (rsp0_valid && rsp1_valid) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_both: rsp0_valid=1 rsp1_valid=1, required at most one");
            end else if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: port %0d data 0x%08h, required no response",
                         rsp1_valid, rsp1_valid ? rsp1_data : rsp0_data);
            end else begin
                check("rsp_port", {31'd0, rsp1_valid}, {31'd0, exp_q[0].port});
                check("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // Stimulus helpers (called just after a negedge)
    // ---------------------------------------------------------------------------------------
    task automatic drive(input int port, input logic valid, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            req0_valid = valid; req0_we = we; req0_addr = addr; req0_wdata = wdata; req0_be = 1'b0;
        end else begin
            req1_valid = valid; req1_we = we; req1_addr = addr; req1_wdata = wdata; req1_be = 1'b0;
        end
    endtask

    task automatic issue(input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_data);
        bit done = 1'b0;
        drive(port, 1'b1, we, addr, wdata);
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if ((port == 0) ? req0_ready : req1_ready) begin
                done = 1'b1;
                if (!we) exp_q.push_back({port == 1, exp_data});
            end
            @(negedge clk);
        end
        drive(port, 1'b0, 1'b0, 32'd0, 32'd0);
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: port %0d addr 0x%08h not accepted, required ready", port,
                     addr);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
    endtask

    // ---------------------------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        mem_read_ready  = 1'b1;
        mem_write_ready = 1'b1;
        hold            = 1'b0;
        release_one     = 1'b0;
        inject          = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_count0", grant_count0, 0);
        check("rst_count1", grant_count1, 0);
        check("rst_tag_error", tag_error, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_mem_re_we", {mem_re, mem_we}, 0);

        // Single read on port 0, exact end-to-end latency.
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
        #1;
        check("t1_req0_ready", req0_ready, 1);
        check("t1_req1_ready", req1_ready, 0);
        check("t1_mem_re", mem_re, 1);
        check("t1_mem_we", mem_we, 0);
        check("t1_mem_address", mem_address, 32'h10);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t1_rsp0_early_%0d", k), rsp0_valid, 0);
            @(negedge clk);
        end
        check("t1_rsp0_pulse", rsp0_valid, 1);
        check("t1_rsp1_quiet", rsp1_valid, 0);
        @(negedge clk);
        check("t1_rsp0_one_cycle", rsp0_valid, 0);

        // Contention on writes after a fresh reset: 0,1,0,1...
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b1, 1'b1, 32'h200, 32'hA0A00000);
        drive(1, 1'b1, 1'b1, 32'h300, 32'hB1B10000);
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("t2_gnt0_c%0d", i), req0_ready, (i % 2 == 0));
            check($sformatf("t2_gnt1_c%0d", i), req1_ready, (i % 2 == 1));
            check($sformatf("t2_addr_c%0d", i), mem_address, (i % 2 == 0) ? 32'h200 : 32'h300);
            check($sformatf("t2_wdata_c%0d", i), mem_write_data,
                  (i % 2 == 0) ? 32'hA0A00000 : 32'hB1B10000);
            check($sformatf("t2_we_c%0d", i), {mem_we, mem_re}, 2'b10);
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("t2_count0", grant_count0, 4);
        check("t2_count1", grant_count1, 4);

        // Interleaved reads, back to back.
        issue(0, 1'b0, 32'h0, 32'd0, 32'h11111111);
        issue(1, 1'b0, 32'h4, 32'd0, 32'h22222222);
        drain();

        // Read back-pressure while a write on the other port proceeds.
        mem_read_ready = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
        drive(1, 1'b1, 1'b1, 32'h304, 32'hC2C2C2C2);
        #1;
        check("t4_req1_ready", req1_ready, 1);
        check("t4_req0_blocked", req0_ready, 0);
        check("t4_mem_address", mem_address, 32'h304);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("t4_req0_wait_%0d", i), req0_ready, 0);
            @(negedge clk);
        end
        mem_read_ready = 1'b1;
        #1;
        check("t4_req0_go", req0_ready, 1);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drain();

        // Tag FIFO full, then freed by a same-cycle pop.
        hold = 1'b1;
        issue(0, 1'b0, 32'h20, 32'd0, 32'h30303030);
        issue(0, 1'b0, 32'h24, 32'd0, 32'h31313131);
        issue(0, 1'b0, 32'h28, 32'd0, 32'h32323232);
        issue(0, 1'b0, 32'h2C, 32'd0, 32'h33333333);
        drive(1, 1'b1, 1'b0, 32'h30, 32'd0);
        #1;
        check("t5_full_ready", req1_ready, 0);
        check("t5_full_re", mem_re, 0);
        @(negedge clk);
        #1;
        check("t5_full_ready2", req1_ready, 0);
        release_one = 1'b1;
        @(negedge clk);
        release_one = 1'b0;
        #1;
        check("t5_pop_ready", req1_ready, 1);
        check("t5_pop_re", mem_re, 1);
        exp_q.push_back({1'b1, 32'h44444444});
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        hold = 1'b0;
        drain();
        check("t5_count0", grant_count0, 10);
        check("t5_count1", grant_count1, 7);

        // Ownerless return beat, then reset.
        check("t6_tag_error_pre", tag_error, 0);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        @(negedge clk);
        #1;
        check("t6_tag_error", tag_error, 1);
        check("t6_rsp_quiet", {rsp0_valid, rsp1_valid}, 0);
        @(negedge clk);
        check("t6_tag_error_sticky", tag_error, 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("t6_rst_tag_error", tag_error, 0);
        check("t6_rst_count0", grant_count0, 0);
        check("t6_rst_count1", grant_count1, 0);
        check("t6_rst_rsp", {rsp0_valid, rsp1_valid}, 0);
        check("t6_rst_rsp_data", rsp0_data | rsp1_data, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("end_scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
